// File: rtl/id_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage scoreboard / forwarding block.
package id_scoreboard_pkg;
  localparam int   ZERO_REG     = 0;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   ID_FWD_MAX   = 8;

  typedef enum logic [1:0] {WR_NONE, WR_LOAD, WR_DIV} wr_kind_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/id_scoreboard_if.sv
// ID-stage issue / operand / forwarding bundle between the decoder (master) and the scoreboard (slave).
interface id_scoreboard_if #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32,
  parameter int NUM_FWD     = 2
);
  logic                           issue_valid_i;
  logic                           flush_i;
  logic                           issue_we_i;
  logic [RADDR_WIDTH-1:0]         issue_rd_i;
  logic                           issue_is_load_i;
  logic                           issue_is_div_i;
  logic [RADDR_WIDTH-1:0]         rs1_i, rs2_i;
  logic                           rs1_re_i, rs2_re_i;
  logic [RDATA_WIDTH-1:0]         reg1_rdata_i, reg2_rdata_i;
  logic [NUM_FWD-1:0]             fwd_we_i;
  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i;
  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i;
  logic [RDATA_WIDTH-1:0]         op1_o, op2_o;
  logic                           stallreq_o;
  logic                           busy_o;

  modport master (
    output issue_valid_i, flush_i, issue_we_i, issue_rd_i, issue_is_load_i, issue_is_div_i,
           rs1_i, rs2_i, rs1_re_i, rs2_re_i, reg1_rdata_i, reg2_rdata_i,
           fwd_we_i, fwd_waddr_i, fwd_wdata_i,
    input  op1_o, op2_o, stallreq_o, busy_o
  );
  modport slave (
    input  issue_valid_i, flush_i, issue_we_i, issue_rd_i, issue_is_load_i, issue_is_div_i,
           rs1_i, rs2_i, rs1_re_i, rs2_re_i, reg1_rdata_i, reg2_rdata_i,
           fwd_we_i, fwd_waddr_i, fwd_wdata_i,
    output op1_o, op2_o, stallreq_o, busy_o
  );
endinterface

// File: rtl/id_fwd_mux.sv
// Priority forward mux for one ID operand: lowest-index matching source wins, x0 is never forwarded.
module id_fwd_mux
  import id_scoreboard_pkg::*;
#(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32,
  parameter int NUM_FWD     = 2
) (
  input  logic                           re_i,
  input  logic [RADDR_WIDTH-1:0]         rs_i,
  input  logic [RDATA_WIDTH-1:0]         rdata_i,
  input  logic [NUM_FWD-1:0]             fwd_we_i,
  input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*RDATA_WIDTH-1:0] fwd_wdata_i,
  output logic [RDATA_WIDTH-1:0]         op_o
);
  localparam int NSRC = (NUM_FWD > ID_FWD_MAX) ? ID_FWD_MAX : NUM_FWD;
  localparam logic [RADDR_WIDTH-1:0] X0 = RADDR_WIDTH'(ZERO_REG);

  // Walk oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    op_o = rdata_i;
    if (re_i == READ_ENABLE && rs_i != X0) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (fwd_we_i[k] == WRITE_ENABLE && fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == rs_i)
          op_o = fwd_wdata_i[k*RDATA_WIDTH +: RDATA_WIDTH];
      end
    end
  end
endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: per-register countdown of in-flight loads (and divides with
// ID_SCOREBOARD_DIV_EN), stall request on pending reads, and per-operand forward muxes.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32,
  parameter int NUM_FWD     = 2,
  parameter int LOAD_LAT    = 1,
  parameter int DIV_LAT     = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  id_scoreboard_if.slave sb
);
  localparam int NREG = 2**RADDR_WIDTH;
`ifdef ID_SCOREBOARD_DIV_EN
  localparam int MAX_LAT = max_int(LOAD_LAT, DIV_LAT);
`else
  localparam int MAX_LAT = LOAD_LAT;
`endif
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [RADDR_WIDTH-1:0] X0 = RADDR_WIDTH'(ZERO_REG);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic     rs1_pend, rs2_pend, div_haz, accept, set_en;
  wr_kind_e kind;

  assign rs1_pend = (sb.rs1_re_i == READ_ENABLE) && (sb.rs1_i != X0) && (cnt_q[sb.rs1_i] != '0);
  assign rs2_pend = (sb.rs2_re_i == READ_ENABLE) && (sb.rs2_i != X0) && (cnt_q[sb.rs2_i] != '0);

  assign sb.stallreq_o = rs1_pend | rs2_pend | div_haz;
  assign sb.busy_o     = |cnt_q;
  assign accept        = sb.issue_valid_i & ~sb.stallreq_o & ~sb.flush_i & ~rst_i;
  assign set_en        = accept && (sb.issue_we_i == WRITE_ENABLE) && (sb.issue_rd_i != X0);

  always_comb begin
    kind = WR_NONE;
`ifdef ID_SCOREBOARD_DIV_EN
    if (sb.issue_is_div_i)       kind = WR_DIV;
    else if (sb.issue_is_load_i) kind = WR_LOAD;
`else
    if (sb.issue_is_load_i)      kind = WR_LOAD;
`endif
  end

  // A new set on the issuing rd takes precedence over that entry's decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    if (set_en && kind == WR_LOAD) cnt_d[sb.issue_rd_i] = CNT_W'(LOAD_LAT);
`ifdef ID_SCOREBOARD_DIV_EN
    if (set_en && kind == WR_DIV)  cnt_d[sb.issue_rd_i] = CNT_W'(DIV_LAT);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

`ifdef ID_SCOREBOARD_DIV_EN
  // Div tag mirrors "counter belongs to a divide" and drops with the counter reaching 0.
  logic [NREG-1:0] div_q, div_d;

  assign div_haz = sb.issue_valid_i & sb.issue_is_div_i & (|div_q);

  always_comb begin
    for (int r = 0; r < NREG; r++)
      div_d[r] = div_q[r] & (cnt_q[r] > CNT_W'(1));
    if (set_en && kind != WR_NONE) div_d[sb.issue_rd_i] = (kind == WR_DIV);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end
`else
  logic unused_div;
  assign unused_div = sb.issue_is_div_i ^ (DIV_LAT == 0);
  assign div_haz    = 1'b0;
`endif

  id_fwd_mux #(.RADDR_WIDTH(RADDR_WIDTH), .RDATA_WIDTH(RDATA_WIDTH), .NUM_FWD(NUM_FWD)) u_op1 (
    .re_i(sb.rs1_re_i), .rs_i(sb.rs1_i), .rdata_i(sb.reg1_rdata_i),
    .fwd_we_i(sb.fwd_we_i), .fwd_waddr_i(sb.fwd_waddr_i), .fwd_wdata_i(sb.fwd_wdata_i),
    .op_o(sb.op1_o)
  );

  id_fwd_mux #(.RADDR_WIDTH(RADDR_WIDTH), .RDATA_WIDTH(RDATA_WIDTH), .NUM_FWD(NUM_FWD)) u_op2 (
    .re_i(sb.rs2_re_i), .rs_i(sb.rs2_i), .rdata_i(sb.reg2_rdata_i),
    .fwd_we_i(sb.fwd_we_i), .fwd_waddr_i(sb.fwd_waddr_i), .fwd_wdata_i(sb.fwd_wdata_i),
    .op_o(sb.op2_o)
  );
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: two instances (LOAD_LAT 1 and 3, DIV_LAT 4) share one stimulus stream and
// are checked against a ready-cycle reference model.
module tb_id_scoreboard;
  localparam int AW = 5, DW = 32, NF = 2, DIVL = 4;
`ifdef ID_SCOREBOARD_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, valid, flush, we, ld, dv, re1, re2;
  logic [AW-1:0]    rd, rs1, rs2;
  logic [DW-1:0]    rdata1, rdata2;
  logic [NF-1:0]    fwe;
  logic [NF*AW-1:0] fwa;
  logic [NF*DW-1:0] fwd;

  logic [1:0]    o_stall, o_busy;
  logic [DW-1:0] o_op1 [2];
  logic [DW-1:0] o_op2 [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_scoreboard_if #(.RADDR_WIDTH(AW), .RDATA_WIDTH(DW), .NUM_FWD(NF)) bus ();
    assign bus.issue_valid_i   = valid;
    assign bus.flush_i         = flush;
    assign bus.issue_we_i      = we;
    assign bus.issue_rd_i      = rd;
    assign bus.issue_is_load_i = ld;
    assign bus.issue_is_div_i  = dv;
    assign bus.rs1_i           = rs1;
    assign bus.rs2_i           = rs2;
    assign bus.rs1_re_i        = re1;
    assign bus.rs2_re_i        = re2;
    assign bus.reg1_rdata_i    = rdata1;
    assign bus.reg2_rdata_i    = rdata2;
    assign bus.fwd_we_i        = fwe;
    assign bus.fwd_waddr_i     = fwa;
    assign bus.fwd_wdata_i     = fwd;
    assign o_stall[g] = bus.stallreq_o;
    assign o_busy[g]  = bus.busy_o;
    assign o_op1[g]   = bus.op1_o;
    assign o_op2[g]   = bus.op2_o;

    id_scoreboard #(.RADDR_WIDTH(AW), .RDATA_WIDTH(DW), .NUM_FWD(NF),
                    .LOAD_LAT(g == 0 ? 1 : 3), .DIV_LAT(DIVL)) u_dut (
      .clk_i(clk), .rst_i(rst), .sb(bus)
    );
  end

  // Model: a register is pending while the current cycle index is below its ready cycle.
  int rdy [2][32];
  bit mdiv [2][32];
  int cyc;
  bit e_stall [2];
  bit e_busy [2];
  logic [DW-1:0] e_op1, e_op2;
  int n_cmp = 0, n_bad = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] m_fwd(logic re, logic [AW-1:0] rs, logic [DW-1:0] rdat);
    logic [DW-1:0] v;
    bit hit;
    v = rdat; hit = 0;
    if (re && rs != 0)
      for (int k = 0; k < NF; k++)
        if (!hit && fwe[k] && fwa[k*AW +: AW] == rs) begin v = fwd[k*DW +: DW]; hit = 1; end
    return v;
  endfunction

  task automatic idle();
    valid = 0; flush = 0; we = 0; ld = 0; dv = 0; rd = 0;
    rs1 = 0; rs2 = 0; re1 = 0; re2 = 0; rdata1 = 0; rdata2 = 0;
    fwe = 0; fwa = 0; fwd = 0;
  endtask

  task automatic eval();
    bit anyp, anyd;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      anyp = 0; anyd = 0;
      for (int r = 1; r < 32; r++)
        if (cyc < rdy[d][r]) begin anyp = 1; if (mdiv[d][r]) anyd = 1; end
      e_busy[d]  = anyp;
      e_stall[d] = (re1 && rs1 != 0 && cyc < rdy[d][rs1]) || (re2 && rs2 != 0 && cyc < rdy[d][rs2]) ||
                   (DIV_ON && valid && dv && anyd);
    end
    e_op1 = m_fwd(re1, rs1, rdata1);
    e_op2 = m_fwd(re2, rs2, rdata2);
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin rdy[d][r] = 0; mdiv[d][r] = 0; end
      end else if (valid && !e_stall[d] && !flush && we && rd != 0) begin
        if (DIV_ON && dv)  begin rdy[d][rd] = cyc + 1 + DIVL;      mdiv[d][rd] = 1; end
        else if (ld)       begin rdy[d][rd] = cyc + 1 + lat_of(d); mdiv[d][rd] = 0; end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) begin eval(); tick(); end
  endtask

  task automatic test_reset();
    idle(); rst = 1; eval(); tick(); eval(); tick();
    rst = 0; rs1 = 4; re1 = 1; rdata1 = 32'h11; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b0) begin n_bad++; $display("FAIL reset_stall dut%0d got %b want 0", d, o_stall[d]); end
      n_cmp++; if (o_busy[d] !== 1'b0)  begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 0", d, o_busy[d]); end
      n_cmp++; if (o_op1[d] !== 32'h11) begin n_bad++; $display("FAIL reset_op1 dut%0d got %h want 11", d, o_op1[d]); end
    end
    tick();
  endtask

  task automatic test_load_lat();
    int c [2];
    bit gone [2];
    logic [DW-1:0] op_go [2];
    idle(); valid = 1; we = 1; ld = 1; rd = 5; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b0) begin n_bad++; $display("FAIL load_issue_stall dut%0d got %b want 0", d, o_stall[d]); end
    end
    tick();
    ld = 0; rd = 10; rs1 = 5; re1 = 1; fwe = 2'b01; fwa = 10'd5; fwd = {32'h0, 32'h0000CAFE};
    for (int d = 0; d < 2; d++) begin c[d] = 0; gone[d] = 0; op_go[d] = 'x; end
    for (int i = 0; i < 8; i++) begin
      eval();
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (o_stall[d] !== e_stall[d]) begin n_bad++; $display("FAIL load_stall_model dut%0d i%0d got %b want %b", d, i, o_stall[d], e_stall[d]); end
        if (!gone[d]) begin
          if (o_stall[d]) c[d]++; else begin gone[d] = 1; op_go[d] = o_op1[d]; end
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (c[d] != lat_of(d)) begin n_bad++; $display("FAIL load_stall_len dut%0d got %0d want %0d", d, c[d], lat_of(d)); end
      n_cmp++; if (op_go[d] !== 32'hCAFE) begin n_bad++; $display("FAIL load_fwd_op dut%0d got %h want cafe", d, op_go[d]); end
    end
    idle(); drain(4);
  endtask

  task automatic test_fwd_prio();
    idle(); rs1 = 3; re1 = 1; rdata1 = 32'h77; fwe = 2'b11; fwa = {5'd3, 5'd3}; fwd = {32'hBBBB, 32'hAAAA};
    eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_op1[d] !== 32'hAAAA) begin n_bad++; $display("FAIL prio_both dut%0d got %h want aaaa", d, o_op1[d]); end
    end
    tick(); fwe = 2'b10; rs2 = 3; re2 = 1; rdata2 = 32'h55; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_op1[d] !== 32'hBBBB) begin n_bad++; $display("FAIL prio_fwd1 dut%0d got %h want bbbb", d, o_op1[d]); end
      n_cmp++; if (o_op2[d] !== 32'hBBBB) begin n_bad++; $display("FAIL prio_op2 dut%0d got %h want bbbb", d, o_op2[d]); end
    end
    tick(); re1 = 0; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_op1[d] !== 32'h77) begin n_bad++; $display("FAIL prio_re0 dut%0d got %h want 77", d, o_op1[d]); end
    end
    tick();
  endtask

  task automatic test_x0();
    idle(); valid = 1; we = 1; ld = 1; rd = 0; eval(); tick();
    idle(); rs1 = 0; re1 = 1; fwe = 2'b01; fwa = 10'd0; fwd = {32'h0, 32'h1234}; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b0) begin n_bad++; $display("FAIL x0_stall dut%0d got %b want 0", d, o_stall[d]); end
      n_cmp++; if (o_busy[d] !== 1'b0)  begin n_bad++; $display("FAIL x0_busy dut%0d got %b want 0", d, o_busy[d]); end
      n_cmp++; if (o_op1[d] !== 32'h0)  begin n_bad++; $display("FAIL x0_op1 dut%0d got %h want 0", d, o_op1[d]); end
    end
    tick();
  endtask

  task automatic test_flush_reset();
    idle(); valid = 1; flush = 1; we = 1; ld = 1; rd = 7; eval(); tick();
    idle(); rs1 = 7; re1 = 1; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b0) begin n_bad++; $display("FAIL flush_stall dut%0d got %b want 0", d, o_stall[d]); end
      n_cmp++; if (o_busy[d] !== 1'b0)  begin n_bad++; $display("FAIL flush_busy dut%0d got %b want 0", d, o_busy[d]); end
    end
    tick();
    idle(); valid = 1; we = 1; ld = 1; rd = 8; eval(); tick();
    ld = 0; rd = 10; rs1 = 8; re1 = 1; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b1) begin n_bad++; $display("FAIL dep_stall dut%0d got %b want 1", d, o_stall[d]); end
    end
    tick(); rst = 1; eval();
    n_cmp++; if (o_stall[1] !== 1'b1) begin n_bad++; $display("FAIL rst_cycle_stall dut1 got %b want 1", o_stall[1]); end
    tick(); rst = 0; eval();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (o_stall[d] !== 1'b0) begin n_bad++; $display("FAIL post_rst_stall dut%0d got %b want 0", d, o_stall[d]); end
      n_cmp++; if (o_busy[d] !== 1'b0)  begin n_bad++; $display("FAIL post_rst_busy dut%0d got %b want 0", d, o_busy[d]); end
    end
    tick(); idle(); drain(2);
  endtask

  task automatic test_div();
    int c [2];
    bit gone [2];
    int want;
    want = DIV_ON ? DIVL : 0;
    for (int pass = 0; pass < 2; pass++) begin
      idle(); valid = 1; we = 1; dv = 1; rd = (pass == 0) ? 5'd9 : 5'd11; eval(); tick();
      if (pass == 0) begin dv = 0; rd = 10; rs1 = 9; re1 = 1; end
      else           rd = 12;
      for (int d = 0; d < 2; d++) begin c[d] = 0; gone[d] = 0; end
      for (int i = 0; i < 10; i++) begin
        eval();
        for (int d = 0; d < 2; d++) begin
          n_cmp++; if (o_stall[d] !== e_stall[d]) begin n_bad++; $display("FAIL div_stall_model p%0d dut%0d i%0d got %b want %b", pass, d, i, o_stall[d], e_stall[d]); end
          if (!gone[d]) begin if (o_stall[d]) c[d]++; else gone[d] = 1; end
        end
        tick();
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (c[d] != want) begin n_bad++; $display("FAIL div_stall_len p%0d dut%0d got %0d want %0d", pass, d, c[d], want); end
      end
      idle(); drain(8);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      valid = $urandom_range(0, 1); flush = ($urandom_range(0, 9) == 0); we = $urandom_range(0, 1);
      k = $urandom_range(0, 3); ld = (k == 1); dv = (k == 2);
      rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      re1 = $urandom_range(0, 1); re2 = $urandom_range(0, 1);
      rdata1 = $urandom; rdata2 = $urandom;
      fwe = 2'($urandom_range(0, 3));
      fwa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd = {$urandom, $urandom};
      eval();
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (o_stall[d] !== e_stall[d]) begin n_bad++; $display("FAIL rnd_stall dut%0d cyc%0d got %b want %b", d, cyc, o_stall[d], e_stall[d]); end
        n_cmp++; if (o_busy[d] !== e_busy[d])   begin n_bad++; $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", d, cyc, o_busy[d], e_busy[d]); end
        n_cmp++; if (o_op1[d] !== e_op1)        begin n_bad++; $display("FAIL rnd_op1 dut%0d cyc%0d got %h want %h", d, cyc, o_op1[d], e_op1); end
        n_cmp++; if (o_op2[d] !== e_op2)        begin n_bad++; $display("FAIL rnd_op2 dut%0d cyc%0d got %h want %h", d, cyc, o_op2[d], e_op2); end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    cyc = 0; rst = 1;
    for (int d = 0; d < 2; d++) for (int r = 0; r < 32; r++) begin rdy[d][r] = 0; mdiv[d][r] = 0; end
    test_reset();
    test_load_lat();
    test_fwd_prio();
    test_x0();
    test_flush_reset();
    test_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
